axi4_sram_slave: RTL
====================

# axi4_sram_slave

AXI3-style burst responder. It terminates the AXI read/write channels driven by the CPU top-level (4-bit IDs, 4-bit lengths, separate WID) and serialises every burst onto a single-port synchronous SRAM with one-cycle read latency. It serves as the memory-side model and on-chip RAM controller behind the core's AXI master port. One transaction is in flight at a time; reads and writes share the SRAM and are arbitrated in IDLE.

## Interface
- RAM_AW, 16, SRAM word-address width; ram_addr = byte_addr[RAM_AW+1:2]
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  read address; arlock/arcache/arprot ignored
- arvalid in 1, arready out 1
- rid/rdata/rresp/rlast  out  4/32/2/1  read data
- rvalid out 1, rready in 1
- awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2  write address; awlock/awcache/awprot ignored
- awvalid in 1, awready out 1
- wid/wdata/wstrb/wlast  in  4/32/4/1  write data; wid ignored
- wvalid in 1, wready out 1
- bid/bresp  out  4/2  write response
- bvalid out 1, bready in 1
- ram_en  out  1  SRAM access strobe
- ram_wen  out  4  byte write enables; 0 = read
- ram_addr  out  RAM_AW  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid the cycle after ram_en with ram_wen=0

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
- IDLE arbitration:
  - arready = IDLE & arvalid & (rd_prio | !awvalid); awready = IDLE & awvalid & !arready (combinational).
  - rd_prio toggles on each grant and resets to 1.
- AR handshake: latch id, addr, len, size, burst; beat counter = 0; go to RD_ADDR.
- RD_ADDR: ram_en=1, ram_wen=0; go to RD_DATA.
- RD_DATA:
  - rvalid=1; rdata is ram_rdata, registered on RD_DATA entry and held stable while stalled.
  - rid = latched id; rresp=2'b00; rlast = (count==len).
  - On rready: if last, go to IDLE; else advance address, count+1, go to RD_ADDR.
- AW handshake: latch fields; go to WR_DATA; resp_err=0.
- WR_DATA:
  - wready=1. Each wvalid beat drives ram_en=1, ram_wen=wstrb, ram_wdata=wdata at the current address in the same cycle, then advances the address and counter.
  - If wlast != (count==len) on any beat, set resp_err.
  - Exactly len+1 beats are consumed; the final beat moves to WR_RESP.
- WR_RESP: bvalid=1, bid = latched id, bresp = resp_err ? 2'b10 : 2'b00; on bready go to IDLE.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01): address += 1<<size, modulo 2^32, with no 4 KB check.
  - Reserved (11): treated as INCR.
  - WRAP (10): see Configuration.
- Narrow sizes: the full 32-bit word is returned; writes rely on the master's wstrb.

## Timing
- Reset values: arready, awready, wready, rvalid, rlast, bvalid, ram_en = 0; ram_wen = 0; rdata, rid, bid, bresp, rresp, ram_addr, ram_wdata = 0; state IDLE; rd_prio = 1.
- Read: AR handshake at cycle T → ram_en at T+1 → rvalid at T+2.
  - With rready held high: one beat per 2 cycles.
  - A len=3 burst completes its last beat at T+8.
  - arready reasserts in the cycle after the rlast handshake.
- Write:
  - AW handshake at T → wready from T+1.
  - With wvalid held high: one beat per cycle.
  - bvalid in the cycle after the final beat.
- Backpressure: rvalid/bvalid hold until accepted; held outputs do not change.
- Reset mid-burst: all valids and ram_en drop immediately; the burst is abandoned with no further SRAM writes.

## Configuration
- AXI_SLV_WRAP_EN defined:
  - WRAP bursts wrap inside a block of (len+1)<<size bytes, aligned to that size.
  - Only the address bits below log2 of that block size increment; upper bits are held.
  - len must be 1, 3, 7 or 15; any other len with WRAP sets resp_err (write) or rresp=2'b10 on every beat (read).
- Undefined: WRAP behaves exactly as INCR; rresp/bresp unaffected.

## Test plan
- INCR read: arid=5, araddr=0x100, arlen=3, arsize=2, RAM preloaded → 4 beats with data from words 0x40..0x43, rid=5, rlast only on beat 4, first rvalid 2 cycles after the AR handshake.
- INCR write: awaddr=0x20, awlen=1, wstrb=4'b0011 then 4'hF, wlast on beat 2 → ram writes at word 0x08 (wen 0011) and 0x09 (wen 1111), bid echoes awid, bresp=00.
- Wrong wlast: awlen=2 with wlast on beat 2 → three SRAM writes still occur, bresp=2'b10.
- Simultaneous arvalid and awvalid after reset → read granted first; next simultaneous pair → write granted; rready low for 5 cycles holds rdata/rlast stable.
- WRAP: araddr=0x18, arlen=3, arsize=2, burst 10 → addresses 0x18, 0x1C, 0x10, 0x14 with AXI_SLV_WRAP_EN; 0x18, 0x1C, 0x20, 0x24 without.
- aresetn pulsed low during beat 2 of an arlen=7 write → bvalid never asserts, no ram_en after reset, next AW accepted normally.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI3-style single-outstanding burst responder serialising bursts onto a 1-cycle-latency SRAM.
// Optional macro AXI_SLV_WRAP_EN enables true WRAP addressing; otherwise WRAP behaves as INCR.
module axi4_sram_slave #(
    parameter int RAM_AW = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

`ifdef AXI_SLV_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_e;

    state_e      state_q, state_d;
    logic        rd_prio_q, rd_prio_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_first_q, rd_first_d;
    logic        last_beat;
    logic        wrap_bad;
    logic        wr_beat;
    logic [31:0] addr_nxt;
    logic        unused_wid;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // WRAP keeps the bits above the (len+1)<<size block and increments only inside it.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] incr;
        logic [31:0] mask;
        incr = a + (32'd1 << size);
        mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        if (burst == 2'b00) return a;
        if (WrapEn && burst == 2'b10 && wrap_len_ok(len)) return (a & ~mask) | (incr & mask);
        return incr;
    endfunction

    assign last_beat  = (cnt_q == len_q);
    assign wrap_bad   = WrapEn && (burst_q == 2'b10) && !wrap_len_ok(len_q);
    assign addr_nxt   = next_addr(addr_q, len_q, size_q, burst_q);
    assign unused_wid = ^wid;

    assign arready = (state_q == IDLE) && arvalid && (rd_prio_q || !awvalid);
    assign awready = (state_q == IDLE) && awvalid && !arready;

    // First RD_DATA cycle forwards the SRAM output; later stall cycles replay the captured copy.
    assign rvalid = (state_q == RD_DATA);
    assign rdata  = rd_first_q ? ram_rdata : rdata_q;
    assign rid    = id_q;
    assign rresp  = (rvalid && wrap_bad) ? 2'b10 : 2'b00;
    assign rlast  = rvalid && last_beat;

    assign wready = (state_q == WR_DATA);
    assign wr_beat = wready && wvalid;
    assign bvalid = (state_q == WR_RESP);
    assign bid    = id_q;
    assign bresp  = (bvalid && resp_err_q) ? 2'b10 : 2'b00;

    assign ram_en    = (state_q == RD_ADDR) || wr_beat;
    assign ram_wen   = wr_beat ? wstrb : 4'b0000;
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wr_beat ? wdata : 32'd0;

    always_comb begin
        state_d    = state_q;
        rd_prio_d  = rd_prio_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        burst_d    = burst_q;
        resp_err_d = resp_err_q;
        rdata_d    = rdata_q;
        rd_first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arready) begin
                    rd_prio_d = ~rd_prio_q;
                    id_d      = arid;
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    cnt_d     = 4'd0;
                    state_d   = RD_ADDR;
                end else if (awready) begin
                    rd_prio_d  = ~rd_prio_q;
                    id_d       = awid;
                    addr_d     = awaddr;
                    len_d      = awlen;
                    size_d     = awsize;
                    burst_d    = awburst;
                    cnt_d      = 4'd0;
                    resp_err_d = 1'b0;
                    state_d    = WR_DATA;
                end
            end
            RD_ADDR: begin
                rd_first_d = 1'b1;
                state_d    = RD_DATA;
            end
            RD_DATA: begin
                if (rd_first_q) rdata_d = ram_rdata;
                if (rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_nxt;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    if ((wlast != last_beat) || wrap_bad) resp_err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d = addr_nxt;
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
            end
            WR_RESP: begin
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            rd_prio_q  <= 1'b1;
            id_q       <= 4'd0;
            addr_q     <= 32'd0;
            len_q      <= 4'd0;
            cnt_q      <= 4'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            resp_err_q <= 1'b0;
            rdata_q    <= 32'd0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_prio_q  <= rd_prio_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            resp_err_q <= resp_err_d;
            rdata_q    <= rdata_d;
            rd_first_q <= rd_first_d;
        end
    end

endmodule
